// File: rtl/rv32i_pkg.sv
// RV32I decode constants shared by the decode stage: opcodes, funct fields,
// one-hot class bit positions and the immediate format selector.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam int CLS_ALUREG = 0;
    localparam int CLS_ALUIMM = 1;
    localparam int CLS_BRANCH = 2;
    localparam int CLS_LOAD   = 3;
    localparam int CLS_STORE  = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_JALR   = 6;
    localparam int CLS_LUI    = 7;
    localparam int CLS_AUIPC  = 8;
    localparam int NUM_CLS    = 9;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SH,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational immediate extraction: instruction word plus format -> 32-bit
// sign-extended immediate (shift-immediates yield the zero-extended shamt).
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_SH:  imm_o = {27'b0, instr_i[24:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with a single registered output slot and valid/ready flow.
// Optional macro ID_STAGE_FWD_EN forwards writeback data into operands at capture.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8:0]      out_cls,
    output logic [7:0]      out_funct3oh,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign rf_raddr1 = rs1_addr;
    assign rf_raddr2 = rs2_addr;

    logic               valid_q, valid_d;
    logic [NUM_CLS-1:0] cls_q, cls_d;
    logic               illegal_q, illegal_d;
    logic [7:0]         f3oh_q, f3oh_d;
    logic [6:0]         f7_q, f7_d;
    logic [XLEN-1:0]    rs1_q, rs1_d;
    logic [XLEN-1:0]    rs2_q, rs2_d;
    logic [XLEN-1:0]    imm_q;
    logic [XLEN-1:0]    pc_q;
    logic [4:0]         rd_q;

    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm;
    logic            f7_keep;
    logic            capture;
    logic [XLEN-1:0] rs1_opnd;
    logic [XLEN-1:0] rs2_opnd;

    imm_gen u_imm_gen (
        .instr_i (in_instr),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    for (genvar gi = 0; gi < 8; gi++) begin : g_f3oh
        assign f3oh_d[gi] = (funct3 == 3'(gi));
    end

    always_comb begin
        cls_d     = '0;
        illegal_d = 1'b0;
        fmt       = IMM_NONE;
        f7_keep   = 1'b0;
        case (opcode)
            OPC_OP: begin
                f7_keep = 1'b1;
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)))
                    cls_d[CLS_ALUREG] = 1'b1;
                else
                    illegal_d = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only shift-immediates carry a real funct7; ADDI imm[10] must not look like SUB.
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    fmt     = IMM_SH;
                    f7_keep = 1'b1;
                end else begin
                    fmt = IMM_I;
                end
                if ((funct3 == F3_SLL && funct7 != F7_BASE) ||
                    (funct3 == F3_SRL_SRA && funct7 != F7_BASE && funct7 != F7_ALT))
                    illegal_d = 1'b1;
                else
                    cls_d[CLS_ALUIMM] = 1'b1;
            end
            OPC_BRANCH: begin fmt = IMM_B; cls_d[CLS_BRANCH] = 1'b1; end
            OPC_LOAD:   begin fmt = IMM_I; cls_d[CLS_LOAD]   = 1'b1; end
            OPC_STORE:  begin fmt = IMM_S; cls_d[CLS_STORE]  = 1'b1; end
            OPC_JAL:    begin fmt = IMM_J; cls_d[CLS_JAL]    = 1'b1; end
            OPC_JALR:   begin fmt = IMM_I; cls_d[CLS_JALR]   = 1'b1; end
            OPC_LUI:    begin fmt = IMM_U; cls_d[CLS_LUI]    = 1'b1; end
            OPC_AUIPC:  begin fmt = IMM_U; cls_d[CLS_AUIPC]  = 1'b1; end
            default:    illegal_d = 1'b1;
        endcase
        f7_d = f7_keep ? funct7 : 7'h00;
    end

    always_comb begin
        rs1_opnd = (rs1_addr == 5'd0) ? '0 : rf_rdata1;
        rs2_opnd = (rs2_addr == 5'd0) ? '0 : rf_rdata2;
`ifdef ID_STAGE_FWD_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs1_addr)
            rs1_opnd = wb_data;
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs2_addr)
            rs2_opnd = wb_data;
`endif
        rs1_d = rs1_opnd;
        rs2_d = cls_d[CLS_ALUIMM] ? imm : rs2_opnd;
    end

`ifndef ID_STAGE_FWD_EN
    logic wb_unused;
    assign wb_unused = ^{wb_en, wb_rd, wb_data};
`endif

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (capture)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            cls_q     <= '0;
            illegal_q <= 1'b0;
            f3oh_q    <= '0;
            f7_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                cls_q     <= cls_d;
                illegal_q <= illegal_d;
                f3oh_q    <= f3oh_d;
                f7_q      <= f7_d;
                rs1_q     <= rs1_d;
                rs2_q     <= rs2_d;
                imm_q     <= (cls_d[CLS_ALUREG]) ? '0 : imm;
                pc_q      <= in_pc;
                rd_q      <= in_instr[11:7];
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_cls      = cls_q;
    assign out_illegal  = illegal_q;
    assign out_funct3oh = f3oh_q;
    assign out_funct7   = f7_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_imm      = imm_q;
    assign out_pc       = pc_q;
    assign out_rd       = rd_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Ports: clk  in  1  sole clock, rising edge.
REQ-003 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 Ports: in_valid/in_ready  in/out  1/1  fetch handshake; in_instr, in_pc  in  32/32  instruction word and its PC.
REQ-005 Ports: flush  in  1  kill the held instruction and drop the incoming one.
REQ-006 Ports: rf_raddr1, rf_raddr2  out  5/5  equal in_instr[19:15], [24:20]; rf_rdata1, rf_rdata2  in  32/32  same-cycle combinational read data.
REQ-007 Ports: wb_en, wb_rd, wb_data  in  1/5/32  writeback forwarding source.
REQ-008 Ports: out_valid/out_ready  out/in  1/1  execute handshake.
REQ-009 Ports: out_cls  out  9  one-hot class: [0]ALUreg [1]ALUimm [2]Branch [3]Load [4]Store [5]JAL [6]JALR [7]LUI [8]AUIPC.
REQ-010 Ports: out_funct3oh  out  8  one-hot of funct3; out_funct7  out  7; out_rs1, out_rs2, out_imm, out_pc  out  32 each; out_rd  out  5; out_illegal  out  1.

Function
REQ-011 Single output register stage; in_ready SHALL equal !out_valid | out_ready (combinational).
REQ-012 Capture SHALL occur on in_valid & in_ready & !flush; outputs valid the next cycle (latency 1).
REQ-013 out_valid SHALL clear when out_ready & out_valid and no capture occurs in that cycle.
REQ-014 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-015 flush SHALL take priority: next cycle out_valid=0 regardless of in_valid/out_ready.
REQ-016 out_funct3oh SHALL equal 1<<in_instr[14:12] for every class.
REQ-017 out_funct7 SHALL be in_instr[31:25] for ALUreg and for ALUimm with funct3=001/101; 0 otherwise (ADDI with imm[10]=1 never yields SUB).
REQ-018 out_imm SHALL be the sign-extended I/S/B/U/J immediate per class; 0 for ALUreg.
REQ-019 out_rs2 SHALL be out_imm for ALUimm, else the rs2 operand; out_rs1 the rs1 operand.
REQ-020 Operands with register address 0 SHALL be 0 irrespective of rf_rdata.
REQ-021 out_illegal SHALL be 1 and out_cls 0 for: unknown opcode; ALUreg funct7 not 0x00/0x20; funct7=0x20 with funct3 not 000/101; SLLI funct7!=0; SRLI/SRAI funct7 not 0x00/0x20.
REQ-022 Illegal instructions SHALL still pass the handshake with out_valid=1.

Reset
REQ-023 On rst_n low, out_valid, out_cls, out_illegal and all data outputs SHALL be 0 immediately; in_ready=1 while in reset and after release.
REQ-024 Reset mid-handshake SHALL discard the held instruction without an out_valid pulse.

Configuration
REQ-025 Macro ID_STAGE_FWD_EN: when defined, at capture an operand whose nonzero address equals wb_rd with wb_en=1 SHALL take wb_data instead of rf_rdata.
REQ-026 Without ID_STAGE_FWD_EN, wb_* ports SHALL exist but be ignored; the register file is then required to be write-first.

Structure
REQ-027 Package rv32i_pkg SHALL hold opcode constants, funct3/funct7 constants, class bit indices and the immediate-format enum.
REQ-028 Sub-module imm_gen (combinational, instr+format -> 32-bit immediate) SHALL be instantiated once.

Verification
REQ-029 0x00500093 (ADDI x1,x0,5), out_ready=1 -> next cycle out_valid=1, out_cls=0x002, funct3oh=0x01, funct7=0, rs1=0, rs2=5, rd=1.
REQ-030 0x4030D113 (SRAI x2,x1,3), rf_rdata1=0x80000000 -> funct3oh=0x20, funct7=0x20, rs1=0x80000000, rs2=3, rd=2.
REQ-031 Capture BEQ, hold out_ready=0 three cycles -> outputs stable, in_ready=0; out_ready=1 -> in_ready=1 same cycle.
REQ-032 flush=1 with in_valid=1 and held valid instruction -> next cycle out_valid=0, no capture.
REQ-033 0x002081B3 (ADD x3,x1,x2), rf_rdata1=0, wb_en=1, wb_rd=1, wb_data=0x1234 -> out_rs1=0x1234 with ID_STAGE_FWD_EN, 0 without.
REQ-034 0xFFFFFFFF -> out_valid=1, out_illegal=1, out_cls=0; rst_n low mid-stall -> out_valid=0 immediately.
